// File: rtl/load_store_unit_if.sv
// Word-bus interface between the load/store unit and data memory.
//   bus_valid/bus_ready : request handshake (master -> slave)
//   bus_we/addr/wdata/wstrb : request payload, stable while bus_valid
//   bus_rvalid/bus_rdata : read response (slave -> master)
interface load_store_unit_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns the single-cycle core's data-memory request
// into a valid/ready word-bus transaction, places store lanes, extracts and
// extends load data, and stalls the core until the access completes.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   req_read, req_write   : core load/store request (held while stall=1)
//   addr, wdata, funct3   : byte address, low-aligned store data, size/sign
//   stall                 : core holds PC/instruction while 1
//   rdata                 : extended load result, valid in DONE only
//   misalign_err, bus_err : one-cycle pulses (dropped request / timeout)
//   bus                   : word-bus master modport
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_err,
  load_store_unit_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic        w_timeout;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic        r_bus_err;

  logic        w_one_req, w_any_req, w_f3_legal, w_aligned, w_accept, w_drop;
  logic [31:0] w_st_wdata, w_ld;
  logic [3:0]  w_st_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // ---------------- request decode (IDLE only) ----------------
  assign w_one_req = req_read ^ req_write;
  assign w_any_req = req_read | req_write;

  always_comb begin
    w_f3_legal = 1'b0;
    if (req_write) w_f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else           w_f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                                (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  always_comb begin
    w_aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && w_one_req && w_f3_legal && w_aligned;
  assign w_drop   = (r_state == S_IDLE) && w_any_req && !w_accept;

  // ---------------- store lane placement ----------------
  always_comb begin
    w_st_wdata = wdata;
    w_st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{wdata[7:0]}};
        w_st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{wdata[15:0]}};
        w_st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // ---------------- load extraction ----------------
  always_comb begin
    w_byte = bus.bus_rdata[7:0];
    case (r_lo)
      2'd1:    w_byte = bus.bus_rdata[15:8];
      2'd2:    w_byte = bus.bus_rdata[23:16];
      2'd3:    w_byte = bus.bus_rdata[31:24];
      default: ;
    endcase
    w_half = r_lo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (r_f3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'h0, w_byte};
      3'b101:  w_ld = {16'h0, w_half};
      default: w_ld = bus.bus_rdata;
    endcase
  end

  // Timeout fires in the cycle whose count would reach TIMEOUT_CYCLES,
  // so exactly TIMEOUT_CYCLES cycles are spent in REQ/WAIT_RESP.
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  // ---------------- FSM next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_REQ;
      S_REQ: begin
        if (bus.bus_ready)  w_next = r_we ? S_DONE : S_WAIT;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WAIT: begin
        if (bus.bus_rvalid) w_next = S_DONE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_f3      <= '0;
      r_lo      <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_we    <= req_write;
          r_addr  <= {addr[31:2], 2'b00};
          r_wdata <= req_write ? w_st_wdata : 32'h0;
          r_wstrb <= req_write ? w_st_wstrb : 4'b0000;
          r_f3    <= funct3;
          r_lo    <= addr[1:0];
          r_cnt   <= '0;
          r_rdata <= '0;
        end
        S_REQ: begin
          if (bus.bus_ready) r_cnt <= '0;
          else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else r_cnt <= w_cnt_inc;
        end
        S_WAIT: begin
          if (bus.bus_rvalid) r_rdata <= w_ld;
          else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else r_cnt <= w_cnt_inc;
        end
        // rdata is only meaningful for the single DONE cycle
        S_DONE:  r_rdata <= '0;
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign bus.bus_valid = (r_state == S_REQ);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_wstrb = r_wstrb;
  assign stall         = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;
  assign rdata         = r_rdata;
  assign misalign_err  = w_drop;
  assign bus_err       = r_bus_err;
endmodule
